// File: rtl/vga_timing_gen.sv
// VGA raster generator: programmable timing and sync polarity, integer pixel/line
// replication, and a 1-cycle-latency pixel-fetch port feeding registered colour/sync outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_PULSE    = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_PULSE    = 2,
  parameter int V_BACK     = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_W    = 4,
  parameter int SCALE_LOG2 = 0
) (
  input  logic                 CLK25MHZ,
  input  logic                 ck_rst,
  output logic                 pix_req,
  output logic [9:0]           pix_x,
  output logic [9:0]           pix_y,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 de,
  output logic                 next_line,
  output logic [9:0]           next_y,
  output logic                 frame_start,
  output logic                 vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FRONT + V_PULSE);
  localparam logic [VW-1:0] REP_MASK   = VW'((1 << SCALE_LOG2) - 1);
  localparam logic          HS_ON      = (HS_POL != 0);
  localparam logic          VS_ON      = (VS_POL != 0);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic          active, hsync, vsync;
  logic [VW-1:0] l_row;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end

    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync  = (h_cnt_q >= H_SYNC_ON) && (h_cnt_q < H_SYNC_OFF);
    vsync  = (v_cnt_q >= V_SYNC_ON) && (v_cnt_q < V_SYNC_OFF);

    pix_req     = active;
    pix_x       = active ? 10'(h_cnt_q >> SCALE_LOG2) : '0;
    pix_y       = active ? 10'(v_cnt_q >> SCALE_LOG2) : '0;
    frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    vblank      = (v_cnt_q >= V_ACT);

    // Prefetch the row the next line will show, once per replica group.
    l_row     = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    next_line = (h_cnt_q == H_SYNC_ON) && (l_row < V_ACT) && ((l_row & REP_MASK) == '0);
    next_y    = next_line ? 10'(l_row >> SCALE_LOG2) : '0;

    act1_d = active;
    hs1_d  = hsync;
    vs1_d  = vsync;

    // pix_rgb answers the request made one cycle earlier, now in stage 1.
    de_d = act1_q;
    r_d  = act1_q ? pix_rgb[3*COLOR_W-1:2*COLOR_W] : '0;
    g_d  = act1_q ? pix_rgb[2*COLOR_W-1:COLOR_W]   : '0;
    b_d  = act1_q ? pix_rgb[COLOR_W-1:0]           : '0;
    hs_d = hs1_q ? HS_ON : ~HS_ON;
    vs_d = vs1_q ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge CLK25MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de_q    <= de_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign vga_r  = r_q;
  assign vga_g  = g_q;
  assign vga_b  = b_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign de     = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster with 2x replication and mixed sync polarity,
// per-cycle expectations from a position-arithmetic model, popped by a separate monitor.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HP = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VP = 2, VB = 1;
  localparam int HT = HA + HF + HP + HB;
  localparam int VT = VA + VF + VP + VB;
  localparam int S = 1;
  localparam int REP = 1 << S;
  localparam int HSP = 1, VSP = 0;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          ck_rst = 1'b1;
  logic [11:0]   pix_rgb = '0;
  logic          pix_req, vga_hs, vga_vs, de, next_line, frame_start, vblank;
  logic [9:0]    pix_x, pix_y, next_y;
  logic [CW-1:0] vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CW), .SCALE_LOG2(S)
  ) dut (
    .CLK25MHZ(clk), .ck_rst(ck_rst),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .de(de),
    .next_line(next_line), .next_y(next_y),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p;
    logic        req, fs, vb, nl, de, hs, vs;
    logic [9:0]  x, y, ny;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int nl_seen = 0;

  task automatic chk(string nm, int p, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, p, got, want);
    end
  endtask

  // Expected DUT view during cycle p after release; rgb is what the bench drives in cycle p-1.
  function automatic exp_t expect_at(int p, logic [11:0] rgb);
    exp_t e;
    int h, v, l, q;
    e.p  = p;
    h    = p % HT;
    v    = (p / HT) % VT;
    e.req = (h < HA) && (v < VA);
    e.x   = e.req ? 10'(h / REP) : 10'd0;
    e.y   = e.req ? 10'(v / REP) : 10'd0;
    e.fs  = (h == 0) && (v == 0);
    e.vb  = (v >= VA);
    l     = (v + 1) % VT;
    e.nl  = (h == HA + HF) && (l < VA) && (l % REP == 0);
    e.ny  = e.nl ? 10'(l / REP) : 10'd0;
    e.de  = 1'b0;
    e.rgb = '0;
    e.hs  = (HSP == 0);
    e.vs  = (VSP == 0);
    if (p >= 2) begin
      q = p - 2;
      h = q % HT;
      v = (q / HT) % VT;
      e.de  = (h < HA) && (v < VA);
      e.rgb = e.de ? rgb : 12'd0;
      if (h >= HA + HF && h < HA + HF + HP) e.hs = (HSP != 0);
      if (v >= VA + VF && v < VA + VF + VP) e.vs = (VSP != 0);
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pix_req", e.p, 32'(pix_req), 32'(e.req));
        chk("pix_x", e.p, 32'(pix_x), 32'(e.x));
        chk("pix_y", e.p, 32'(pix_y), 32'(e.y));
        chk("frame_start", e.p, 32'(frame_start), 32'(e.fs));
        chk("vblank", e.p, 32'(vblank), 32'(e.vb));
        chk("next_line", e.p, 32'(next_line), 32'(e.nl));
        chk("next_y", e.p, 32'(next_y), 32'(e.ny));
        chk("de", e.p, 32'(de), 32'(e.de));
        chk("rgb", e.p, 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
        chk("vga_hs", e.p, 32'(vga_hs), 32'(e.hs));
        chk("vga_vs", e.p, 32'(vga_vs), 32'(e.vs));
        if (next_line) nl_seen++;
      end
    end
  end

  task automatic check_reset(int tag);
    chk("rst_de", tag, 32'(de), 32'd0);
    chk("rst_rgb", tag, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("rst_hs", tag, 32'(vga_hs), (HSP != 0) ? 32'd0 : 32'd1);
    chk("rst_vs", tag, 32'(vga_vs), (VSP != 0) ? 32'd0 : 32'd1);
    chk("rst_next_line", tag, 32'(next_line), 32'd0);
    chk("rst_next_y", tag, 32'(next_y), 32'd0);
    chk("rst_frame_start", tag, 32'(frame_start), 32'd1);
    chk("rst_pix_x", tag, 32'(pix_x), 32'd0);
  endtask

  // Release reset on a falling edge and stream ncyc cycles of stimulus.
  task automatic run_phase(int ncyc, bit patterned);
    exp_t prev;
    logic [11:0] r;
    @(negedge clk);
    ck_rst = 1'b0;
    #1;
    chk("post_release_frame_start", 0, 32'(frame_start), 32'd1);
    chk("post_release_de", 0, 32'(de), 32'd0);
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      if (patterned && k > 0) begin
        prev = expect_at(k - 1, 12'd0);
        r = {prev.x[3:0], prev.y[3:0], ~prev.x[3:0]};
      end else begin
        r = 12'($urandom);
      end
      pix_rgb = r;
      exp_q.push_back(expect_at(k + 1, r));
    end
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n1;
    repeat (3) @(posedge clk);
    #3;
    check_reset(-1);

    // End phase 1 a few pixels into an active line so reset lands mid-line.
    n1 = HT * (13 + int'($urandom_range(0, 2))) + 7;
    run_phase(n1, 1'b0);
    chk("queue_drained_1", n1, 32'(exp_q.size()), 32'd0);
    ck_rst = 1'b1;
    #1;
    check_reset(-2);
    repeat (2) @(posedge clk);
    #1;
    check_reset(-3);

    nl_seen = 0;
    run_phase(2 * HT * VT, 1'b1);
    chk("queue_drained_2", 0, 32'(exp_q.size()), 32'd0);
    chk("next_line_per_2frames", 0, 32'(nl_seen), 32'(2 * (VA / REP)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
